// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up_counter to N_REQ requesters as an
// interval timer, granting each winner exclusive use for its own length L.
module counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*CNT_W-1:0]   i_len,
    input  logic                     i_abort,
    input  logic [CNT_W-1:0]         i_count,
    output logic                     o_cnt_reset,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_done,
    output logic                     o_aborted,
    output logic                     o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   owner_s;
    logic [IDX_W-1:0]   win_s;
    logic [IDX_W-1:0]   ptr_next_s;
    logic [CNT_W-1:0]   len_r;
    logic [CNT_W-1:0]   win_len_s;
    logic               found_s;
    logic               abort_s;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   done_r;
    logic               aborted_r;
    logic               busy_r;
    logic               cnt_reset_r;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin : arb_search
        int pos;
        found_s   = 1'b0;
        win_s     = {IDX_W{1'b0}};
        win_len_s = {CNT_W{1'b0}};
        pos       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(ptr_r) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end else begin
                pos = pos;
            end
            if (!found_s && i_req[pos]) begin
                found_s   = 1'b1;
                win_s     = IDX_W'(pos);
                win_len_s = i_len[pos*CNT_W +: CNT_W];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next-state decode; an abort outranks a length match in the same cycle.
    always_comb begin
        state_s = state_r;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_s = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_s = ST_DONE;
                    abort_s = 1'b1;
                end else if (i_count == len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Owner to use for the next cycle's outputs and the pointer after this grant.
    always_comb begin
        if ((state_r == ST_IDLE) && found_s) begin
            owner_s = win_s;
        end else begin
            owner_s = owner_r;
        end
        if (owner_r == IDX_W'(N_REQ - 1)) begin
            ptr_next_s = {IDX_W{1'b0}};
        end else begin
            ptr_next_s = owner_r + IDX_W'(1);
        end
    end

    // State, latched grant context and registered outputs driven from the next state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            len_r       <= {CNT_W{1'b0}};
            grant_r     <= {N_REQ{1'b0}};
            done_r      <= {N_REQ{1'b0}};
            aborted_r   <= 1'b0;
            busy_r      <= 1'b0;
            cnt_reset_r <= 1'b1;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            if ((state_r == ST_IDLE) && found_s) begin
                len_r <= win_len_s;
            end else begin
                len_r <= len_r;
            end
            if (state_r == ST_DONE) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if ((state_s == ST_CLEAR) || (state_s == ST_RUN)) begin
                grant_r <= to_onehot(owner_s);
            end else begin
                grant_r <= {N_REQ{1'b0}};
            end
            if (state_s == ST_DONE) begin
                done_r <= to_onehot(owner_s);
            end else begin
                done_r <= {N_REQ{1'b0}};
            end
            aborted_r   <= (state_s == ST_DONE) && abort_s;
            busy_r      <= (state_s != ST_IDLE);
            cnt_reset_r <= (state_s != ST_RUN);
        end
    end

    assign o_grant     = grant_r;
    assign o_done      = done_r;
    assign o_aborted   = aborted_r;
    assign o_busy      = busy_r;
    assign o_cnt_reset = cnt_reset_r;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural model of the shared up_counter.
module tb_counter_arbiter;

    logic        clk;
    logic        i_reset_n;
    logic [3:0]  i_req;
    logic [15:0] i_len;
    logic        i_abort;
    logic [3:0]  cnt;
    logic        o_cnt_reset;
    logic [3:0]  o_grant;
    logic [3:0]  o_done;
    logic        o_aborted;
    logic        o_busy;

    int total;
    int passed;
    int failed;

    counter_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_req       (i_req),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .i_count     (cnt),
        .o_cnt_reset (o_cnt_reset),
        .o_grant     (o_grant),
        .o_done      (o_done),
        .o_aborted   (o_aborted),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared up_counter: synchronous active-high reset, free-running increment.
    always_ff @(posedge clk) begin
        if (o_cnt_reset) cnt <= 4'd0;
        else             cnt <= cnt + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] grant, input logic [3:0] done,
                            input logic aborted, input logic busy, input logic cnt_reset);
        chk({tag, ".grant"},     32'(o_grant),     32'(grant));
        chk({tag, ".done"},      32'(o_done),      32'(done));
        chk({tag, ".aborted"},   32'(o_aborted),   32'(aborted));
        chk({tag, ".busy"},      32'(o_busy),      32'(busy));
        chk({tag, ".cnt_reset"}, 32'(o_cnt_reset), 32'(cnt_reset));
    endtask

    // Starts in the IDLE cycle where the request is sampled, ends in the following IDLE cycle.
    task automatic grant_seq(input string tag, input logic [3:0] oh, input int len, input int abort_at,
                             input logic [3:0] next_req, input logic [15:0] next_len);
        tick();
        i_req = next_req;
        i_len = next_len;
        chk_outs({tag, ".clear"}, oh, 4'b0000, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k <= len; k++) begin
            tick();
            i_abort = 1'b0;
            chk_outs({tag, ".run"}, oh, 4'b0000, 1'b0, 1'b1, 1'b0);
            chk({tag, ".count"}, 32'(cnt), 32'(k));
            if (k == abort_at) begin
                i_abort = 1'b1;
                break;
            end
        end
        tick();
        i_abort = 1'b0;
        chk_outs({tag, ".done"}, 4'b0000, oh, (abort_at >= 0), 1'b1, 1'b1);
        tick();
        chk_outs({tag, ".idle"}, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        i_reset_n = 1'b0; i_req = 4'b0000; i_len = 16'h0000; i_abort = 1'b0;

        // Reset held for two cycles, then a single grant of length 3
        tick(); tick();
        chk_outs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        i_reset_n = 1'b1; i_req = 4'b0001; i_len = 16'h0003;
        grant_seq("single", 4'b0001, 3, -1, 4'b0000, 16'h0003);

        // All four request from reset, length 1 each
        i_reset_n = 1'b0; i_req = 4'b1111; i_len = 16'h1111;
        tick();
        chk_outs("reset2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        i_reset_n = 1'b1;
        grant_seq("simul0", 4'b0001, 1, -1, 4'b1111, 16'h1111);
        grant_seq("simul1", 4'b0010, 1, -1, 4'b1111, 16'h1111);
        grant_seq("simul2", 4'b0100, 1, -1, 4'b1111, 16'h1111);
        grant_seq("simul3", 4'b1000, 1, -1, 4'b0000, 16'h1111);

        // Fairness between requesters 0 and 2
        i_req = 4'b0101; i_len = 16'h2222;
        grant_seq("fair0", 4'b0001, 2, -1, 4'b0101, 16'h2222);
        grant_seq("fair1", 4'b0100, 2, -1, 4'b0101, 16'h2222);
        grant_seq("fair2", 4'b0001, 2, -1, 4'b0101, 16'h2222);
        grant_seq("fair3", 4'b0100, 2, -1, 4'b0000, 16'h2222);

        // Length boundaries; L0 is changed to 15 while the L=0 grant is in flight
        i_req = 4'b0001; i_len = 16'h2220;
        grant_seq("len0", 4'b0001, 0, -1, 4'b0001, 16'h222F);
        grant_seq("len15", 4'b0001, 15, -1, 4'b0000, 16'h222F);

        // Abort at count 2, then search resumes from index 2; abort coinciding with a match
        i_req = 4'b0010; i_len = 16'h22AF;
        grant_seq("abort", 4'b0010, 10, 2, 4'b1010, 16'h22AF);
        grant_seq("abort_match", 4'b1000, 2, 2, 4'b0000, 16'h22AF);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk_outs("idle_abort", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("idle_abort2", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Move the pointer off 0, then reset in the middle of a RUN
        i_req = 4'b0001; i_len = 16'h2A21;
        grant_seq("pre_rst", 4'b0001, 1, -1, 4'b0100, 16'h2A21);
        tick();
        i_req = 4'b0000;
        chk_outs("mid.clear", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k <= 4; k++) begin
            tick();
            chk("mid.count", 32'(cnt), 32'(k));
        end
        i_reset_n = 1'b0;
        tick();
        chk_outs("mid_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        i_reset_n = 1'b1; i_req = 4'b1111;
        grant_seq("post_rst", 4'b0001, 1, -1, 4'b0000, 16'h2A21);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one `up_counter` among `N_REQ` requesters as an interval timer. It drives the counter's active-high reset, watches `o_count`, and grants exclusive use for a per-requester length of `L` counts. The block sits directly in front of the shared `up_counter` instance: its `o_cnt_reset` feeds the counter's `i_reset`, and the counter's `o_count` feeds its `i_count`. Grants are non-preemptive except through an explicit abort.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `CNT_W`, default 4: counter width, matching `up_counter`.
- `i_clk`  in  1: single clock, rising edge.
- `i_reset_n`  in  1: one clock; reset is synchronous and active-low.
- `i_req`  in  `N_REQ`: level request per requester.
- `i_len`  in  `N_REQ*CNT_W`: target count per requester; slice `k` is bits `[k*CNT_W +: CNT_W]`.
- `i_abort`  in  1: ends the current grant early.
- `i_count`  in  `CNT_W`: shared counter value.
- `o_cnt_reset`  out  1: active-high reset to the shared counter.
- `o_grant`  out  `N_REQ`: one-hot owner, all zeros when none.
- `o_done`  out  `N_REQ`: one-hot, one-cycle completion pulse.
- `o_aborted`  out  1: qualifies `o_done`; set when the grant ended by abort.
- `o_busy`  out  1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, CLEAR, RUN, DONE. All outputs are registered or decoded from state and the latched owner only.
- Reset (`i_reset_n`=0 at an edge):
  - State goes to IDLE.
  - `o_grant`=0, `o_done`=0, `o_aborted`=0, `o_busy`=0, `o_cnt_reset`=1.
  - The round-robin pointer resets to 0.
  - Reset overrides every state, including mid-RUN.
- IDLE:
  - `o_cnt_reset`=1.
  - If `i_req` is nonzero, the winner is the first set bit searching from the pointer upward and wrapping modulo `N_REQ`.
  - The winner's index and its `i_len` slice are latched. Next state is CLEAR.
  - With no request, the FSM stays in IDLE.
- CLEAR:
  - `o_grant` = owner one-hot, `o_cnt_reset`=1 (the counter reads 0 on the next edge).
  - Next state is RUN.
- RUN:
  - `o_grant` = owner, `o_cnt_reset`=0, so the counter increments every cycle.
  - If `i_count` equals the latched `L`, next state is DONE with `o_aborted`=0.
- Abort: `i_abort`=1 in CLEAR or RUN sends the FSM to DONE with `o_aborted`=1. Abort takes priority over a length match in the same cycle. `i_abort` is ignored in IDLE and DONE.
- DONE:
  - `o_grant`=0, `o_done` = owner one-hot, `o_cnt_reset`=1.
  - The pointer becomes (owner+1) mod `N_REQ`.
  - Next state is IDLE.
- Requests:
  - Changes to `i_req` and `i_len` after latching have no effect on the current grant.
  - A request still held after its DONE competes again at the lowest priority.
- Length rules:
  - `L`=0 is legal: RUN lasts one cycle.
  - `L`=2^`CNT_W`−1 matches before the counter wraps.
  - The counter never wraps during a grant.

## Timing
- Cycle t0, IDLE: request sampled.
- Cycle t0+1: CLEAR, grant asserted.
- Cycles t0+2 .. t0+2+L: RUN; `i_count` = 0..L.
- Cycle t0+3+L: DONE, `o_done` pulses.
- Cycle t0+4+L: IDLE.
- Grant width is L+2 cycles. The minimum period between back-to-back grants is L+4 cycles.
- Abort sampled in cycle t: DONE in t+1, `o_grant` low in t+1.
- `o_busy` is high from t0+1 through t0+3+L inclusive.
- A request that arrives during DONE is not seen until the following IDLE cycle.

## Test plan
- Single grant: hold reset low 2 cycles, then `i_req`=0001 and `L0`=3. Required: `o_grant`=0001 for exactly 5 cycles, `i_count` reads 0,1,2,3 in RUN, `o_done`=0001 for 1 cycle with `o_aborted`=0, `o_cnt_reset`=1 in IDLE, CLEAR and DONE.
- Simultaneous requests: `i_req`=1111 with all `L`=1, applied from reset. Required: grants in order 0001, 0010, 0100, 1000, each 3 cycles wide, consecutive grant starts 5 cycles apart, one done pulse per grant in the same order.
- Fairness: `i_req`=0101 held constantly with `L`=2. Required: owners alternate 0,2,0,2 with no owner granted twice in a row.
- Length boundaries: `L0`=0 gives a 2-cycle grant and 1 RUN cycle. `L0`=15 gives a 17-cycle grant, with `i_count` reaching 15 and never 0 after RUN starts.
- Abort: `L1`=10, `i_abort` pulsed when `i_count`=2. Required: DONE on the next cycle with `o_done`=0010 and `o_aborted`=1; the next winner is searched from index 2. Abort pulsed while IDLE has no effect.
- Reset mid-RUN: `i_reset_n`=0 while `i_count`=4. Required: after the edge, all outputs are at reset values and `o_cnt_reset`=1. After release with `i_req`=1111, the first grant goes to requester 0.
